pulse_timestamp_fifo: RTL and testbench

- Downstream consumer of the pulse generator's `pulse_out`.
- Detects each rising edge of the pulse and captures the value of a free-running cycle counter at that moment.
- Buffers timestamps in a small FWFT FIFO and presents them on a valid/ready stream to the readout logic.
- Counts and flags timestamps lost to FIFO overflow.

---
 rtl/pulse_ts_pkg.sv | 13 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/pulse_timestamp_fifo.sv | 91 +++++++++
 tb/tb_pulse_timestamp_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_ts_pkg.sv
// Shared defaults and width helpers for the pulse timestamp capture path.
package pulse_ts_pkg;

    localparam int TS_WIDTH_DEF  = 32;
    localparam int DEPTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF = 16;

    // Level must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push while full is ignored unless a pop frees the slot.
module sync_fifo
    import pulse_ts_pkg::*;
#(
    parameter int WIDTH = TS_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Memory is cleared on reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign level    = count;

endmodule

// File: rtl/pulse_timestamp_fifo.sv
// Timestamps rising edges of pulse_in against a free-running counter and streams them out,
// keeping a sticky overflow flag and a saturating count of timestamps lost to a full FIFO.
module pulse_timestamp_fifo
    import pulse_ts_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pulse_in,
    input  logic                          enable,
    input  logic                          ts_clear,
    output logic [TS_WIDTH-1:0]           ts_data,
    output logic                          ts_valid,
    input  logic                          ts_ready,
    output logic [level_width(DEPTH)-1:0] fifo_level,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_count,
    input  logic                          overflow_clr
);

    logic [TS_WIDTH-1:0] ts_cnt;
    logic                pulse_d;
    logic                rise;
    logic                capture;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else if (ts_clear) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    // pulse_d resets high so a pulse already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_d <= 1'b1;
        end else begin
            pulse_d <= pulse_in;
        end
    end

    assign rise     = pulse_in & ~pulse_d;
    assign capture  = rise & enable;
    assign ts_valid = ~fifo_empty;
    assign pop      = ts_valid & ts_ready;
    assign drop     = capture & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (ts_cnt),
        .pop       (pop),
        .pop_data  (ts_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr) begin
                drop_count <= CNT_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_pulse_timestamp_fifo.sv
// Scoreboard bench: a reference model queues expected timestamps on each captured edge
// and pops them as the design hands data over; a 4-bit-counter instance checks wrap.
module tb_pulse_timestamp_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse_in = 1'b0;
    logic        enable = 1'b1;
    logic        ts_clear = 1'b0;
    logic        ts_ready = 1'b1;
    logic        overflow_clr = 1'b0;

    logic [31:0] ts_data;
    logic        ts_valid;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    logic [3:0]  ts_data_w4;
    logic        ts_valid_w4;
    logic [3:0]  fifo_level_w4;
    logic        overflow_w4;
    logic [15:0] drop_count_w4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    pulse_timestamp_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .pulse_in     (pulse_in),
        .enable       (enable),
        .ts_clear     (ts_clear),
        .ts_data      (ts_data),
        .ts_valid     (ts_valid),
        .ts_ready     (ts_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .overflow_clr (overflow_clr)
    );

    pulse_timestamp_fifo #(.TS_WIDTH(4)) dut_w4 (
        .clk          (clk),
        .rst          (rst),
        .pulse_in     (pulse_in),
        .enable       (enable),
        .ts_clear     (ts_clear),
        .ts_data      (ts_data_w4),
        .ts_valid     (ts_valid_w4),
        .ts_ready     (ts_ready),
        .fifo_level   (fifo_level_w4),
        .overflow     (overflow_w4),
        .drop_count   (drop_count_w4),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model, evaluated mid-cycle when inputs and outputs are both settled.
    logic [63:0] m_cnt;
    logic        m_pd;
    logic [31:0] q[$];
    logic        m_ovf;
    logic [15:0] m_drop;

    always @(negedge clk) begin
        logic pop_m, cap_m, full_m, drop_m;
        if (rst) begin
            m_cnt  = '0;
            m_pd   = 1'b1;
            q.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
            chk_val("rst_valid", ts_valid, 0);
            chk_val("rst_level", fifo_level, 0);
            chk_val("rst_data", ts_data, 0);
            chk_val("rst_ovf", overflow, 0);
            chk_val("rst_drop", drop_count, 0);
        end else begin
            chk_val("valid", ts_valid, q.size() > 0);
            chk_val("level", fifo_level, q.size());
            chk_val("ovf", overflow, m_ovf);
            chk_val("drop", drop_count, m_drop);
            chk_val("w4_valid", ts_valid_w4, q.size() > 0);
            chk_val("w4_level", fifo_level_w4, q.size());
            chk_val("w4_drop", drop_count_w4, m_drop);
            if (q.size() > 0) begin
                chk_val("data", ts_data, q[0]);
                chk_val("w4_data", ts_data_w4, q[0] & 32'hF);
            end
            pop_m  = (q.size() > 0) && ts_ready;
            full_m = (q.size() == DEPTH);
            cap_m  = pulse_in && !m_pd && enable;
            drop_m = cap_m && full_m && !pop_m;
            if (pop_m) void'(q.pop_front());
            if (cap_m && !drop_m) q.push_back(m_cnt[31:0]);
            if (drop_m) begin
                m_ovf  = 1'b1;
                m_drop = overflow_clr ? 16'd1 : (m_drop == 16'hFFFF ? m_drop : m_drop + 16'd1);
            end else if (overflow_clr) begin
                m_ovf  = 1'b0;
                m_drop = '0;
            end
            m_cnt = ts_clear ? 64'd0 : m_cnt + 64'd1;
            m_pd  = pulse_in;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_cyc(input int k);
        while (cyc < k) next_cyc();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse_once(input int k);
        goto_cyc(k);
        pulse_in = 1'b1;
        next_cyc();
        pulse_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        // Single pulse, immediate drain
        do_reset();
        ts_ready = 1'b1;
        pulse_once(15);
        @(negedge clk);
        chk_val("t1_valid16", ts_valid, 1);
        chk_val("t1_data16", ts_data, 15);
        next_cyc();
        @(negedge clk);
        chk_val("t1_valid17", ts_valid, 0);
        chk_val("t1_level17", fifo_level, 0);
        chk_val("t1_ovf", overflow, 0);
        // Edges with enable low are discarded, not dropped
        goto_cyc(20);
        enable = 1'b0;
        pulse_once(20);
        enable = 1'b1;
        goto_cyc(23);

        // Held-high pulse yields one entry
        do_reset();
        ts_ready = 1'b0;
        goto_cyc(5);
        pulse_in = 1'b1;
        goto_cyc(21);
        pulse_in = 1'b0;
        @(negedge clk);
        chk_val("t2_level", fifo_level, 1);
        chk_val("t2_data", ts_data, 5);
        ts_ready = 1'b1;
        next_cyc();
        next_cyc();

        // Pulse already high at reset release is no event
        pulse_in = 1'b1;
        do_reset();
        goto_cyc(3);
        pulse_in = 1'b0;
        @(negedge clk);
        chk_val("t2_release_level", fifo_level, 0);

        // Overflow with ts_ready low, then ordered drain
        do_reset();
        ts_ready = 1'b0;
        for (int i = 0; i < 10; i++) pulse_once(2 + 3 * i);
        goto_cyc(31);
        @(negedge clk);
        chk_val("t3_level", fifo_level, 8);
        chk_val("t3_ovf", overflow, 1);
        chk_val("t3_drop", drop_count, 2);
        chk_val("t3_head", ts_data, 2);
        ts_ready = 1'b1;
        goto_cyc(40);
        @(negedge clk);
        chk_val("t3_drained", fifo_level, 0);

        // Full with simultaneous pop and push
        ts_ready = 1'b0;
        for (int i = 0; i < 8; i++) pulse_once(42 + 2 * i);
        goto_cyc(60);
        ts_ready = 1'b1;
        pulse_in = 1'b1;
        next_cyc();
        ts_ready = 1'b0;
        pulse_in = 1'b0;
        @(negedge clk);
        chk_val("t4_level", fifo_level, 8);
        chk_val("t4_drop", drop_count, 2);
        // Clear coincident with a drop: set wins
        goto_cyc(63);
        pulse_in = 1'b1;
        overflow_clr = 1'b1;
        next_cyc();
        pulse_in = 1'b0;
        overflow_clr = 1'b0;
        @(negedge clk);
        chk_val("t4_clr_ovf", overflow, 1);
        chk_val("t4_clr_drop", drop_count, 1);
        goto_cyc(65);
        overflow_clr = 1'b1;
        next_cyc();
        overflow_clr = 1'b0;
        @(negedge clk);
        chk_val("t4_cleared", overflow, 0);
        ts_ready = 1'b1;
        goto_cyc(75);

        // Counter wrap on the 4-bit instance
        do_reset();
        ts_ready = 1'b1;
        pulse_once(17);
        @(negedge clk);
        chk_val("t5_w4_wrap", ts_data_w4, 1);
        chk_val("t5_w32", ts_data, 17);

        // ts_clear reloads zero
        do_reset();
        goto_cyc(10);
        ts_clear = 1'b1;
        next_cyc();
        ts_clear = 1'b0;
        pulse_once(13);
        @(negedge clk);
        chk_val("t5_clear", ts_data, 2);
        chk_val("t5_clear_w4", ts_data_w4, 2);

        // Asynchronous reset mid-operation
        do_reset();
        ts_ready = 1'b0;
        pulse_once(2);
        pulse_once(4);
        pulse_once(6);
        goto_cyc(9);
        @(negedge clk);
        chk_val("t6_level3", fifo_level, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_val("t6_async_valid", ts_valid, 0);
        chk_val("t6_async_level", fifo_level, 0);
        chk_val("t6_async_drop", drop_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        ts_ready = 1'b1;
        pulse_once(4);
        @(negedge clk);
        chk_val("t6_post_valid", ts_valid, 1);
        chk_val("t6_post_data", ts_data, 4);
        next_cyc();
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
